// File: rtl/cpu_flag_in_pio_if.sv
// Avalon-MM slave bus bundle for cpu_flag_in_pio.
// The CPU side (master) drives address/strobes/write data; the PIO (slave)
// returns registered read data.
interface cpu_flag_in_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/cpu_flag_in_pio.sv
// cpu_flag_in_pio: Avalon-MM input PIO.
// The CPU reads a WIDTH-bit status bus from fabric logic through a
// SYNC_STAGES-deep synchroniser, with per-bit sticky edge capture and a
// maskable level interrupt.
//
// Register map (word offsets):
//   0 DATA          read-only, synchronised in_port
//   1 reserved      reads 0, writes ignored
//   2 IRQ_MASK      read/write
//   3 EDGE_CAPTURE  read; a write clears
//
// Build option: define EDGE_CAP_BITCLR_EN to make EDGE_CAPTURE
// write-1-to-clear per bit. Without it, any write to offset 3 clears every
// capture bit and the write data is ignored.
module cpu_flag_in_pio #(
    parameter int WIDTH       = 8,   // 1..32
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int EDGE_TYPE   = 0    // 0 = rising, 1 = falling, 2 = any
) (
    input  logic                clk,
    input  logic                reset,
    cpu_flag_in_pio_if.slave    bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    // Edge selection folded into two constant enables so both raw edge
    // terms are always consumed.
    localparam logic SEL_RISE = (EDGE_TYPE != 1);
    localparam logic SEL_FALL = (EDGE_TYPE != 0);

    // The arm counter runs to SYNC_STAGES+1 after reset and parks there.
    localparam int              ARM_MAX  = SYNC_STAGES + 1;
    localparam int              ARM_W    = $clog2(ARM_MAX + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_MAX);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    // Register state
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_irq_mask;
    logic [WIDTH-1:0]                  r_edge_capture;
    logic [ARM_W-1:0]                  r_arm_cnt;
    logic [31:0]                       r_readdata;

    // Combinational nets
    logic [WIDTH-1:0] w_sync_q;
    logic             w_armed;
    logic             w_wr_strobe;
    logic             w_mask_wr;
    logic             w_cap_wr;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_cap_next;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_sync_q    = r_sync[SYNC_STAGES-1];
    assign w_armed     = (r_arm_cnt == ARM_DONE);
    assign w_wr_strobe = bus.chipselect & ~bus.write_n;
    assign w_mask_wr   = w_wr_strobe & (bus.address == ADDR_MASK);
    assign w_cap_wr    = w_wr_strobe & (bus.address == ADDR_CAP);

    // Write data above WIDTH has no home; keep it visibly consumed.
    assign w_unused_wdata = ^bus.writedata;

`ifdef EDGE_CAP_BITCLR_EN
    // Write-1-to-clear: only bits written as 1 are cleared.
    assign w_cap_clr = w_cap_wr ? bus.writedata[WIDTH-1:0] : '0;
`else
    // Any write to the capture register wipes all bits.
    assign w_cap_clr = {WIDTH{w_cap_wr}};
`endif

    // Synchroniser chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_q;
        end
    end

    // Arm counter: hides the reset-to-live transition of the synchroniser
    // so inputs held high through reset do not look like rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
        end
    end

    // Per-bit edge detect and capture next-state. A new edge on a bit
    // overrides a clear of that same bit in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_rise;
            logic w_fall;
            assign w_rise         = w_sync_q[gi] & ~r_prev[gi];
            assign w_fall         = ~w_sync_q[gi] & r_prev[gi];
            assign w_edge_set[gi] = w_armed & ((SEL_RISE & w_rise) | (SEL_FALL & w_fall));
            assign w_cap_next[gi] = w_edge_set[gi] | (r_edge_capture[gi] & ~w_cap_clr[gi]);
        end
    endgenerate

    // CPU-visible mask and sticky capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            if (w_mask_wr) begin
                r_irq_mask <= bus.writedata[WIDTH-1:0];
            end
            r_edge_capture <= w_cap_next;
        end
    end

    // Read mux, zero-extended to the 32-bit bus; reserved offset reads 0.
    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_sync_q;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_CAP:  w_rd_mux[WIDTH-1:0] = r_edge_capture;
            default:   w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;

    // Level interrupt straight from the registers.
    assign irq = |(r_edge_capture & r_irq_mask);

endmodule
